// File: rtl/noise_ctrl_sched.sv
// Noise channel control front-end: decodes noise-control register writes, holds
// feedback mode / rate select, and generates LFSR reseed and shift strobes.
//
// state   | meaning
// S_IDLE  | accepting bytes; divider or tone3 pulse drives shift_en
// S_CLEAR | one-cycle LFSR reseed; writes stalled, counter re-phased, shifts suppressed
module noise_ctrl_sched #(
   parameter int BASE_DIV = 16,
   parameter int CNT_W    = 8
) (
   input  logic       noise_clk,
   input  logic       rst,
   input  logic       wr_valid,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   input  logic       tone3_pulse,
   output logic       shift_en,
   output logic       lfsr_clr,
   output logic       fb_mode,
   output logic [1:0] rate_sel,
   output logic       busy
);

   localparam logic [CNT_W-1:0] TC_R0 = CNT_W'(BASE_DIV - 1);
   localparam logic [CNT_W-1:0] TC_R1 = CNT_W'(2 * BASE_DIV - 1);
   localparam logic [CNT_W-1:0] TC_R2 = CNT_W'(4 * BASE_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [2:0]       NOISE_REG = 3'b110;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t           state;
   logic [2:0]       ptr;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] term;
   logic             accept;
   logic             noise_wr;
   logic             tone_mode;

   always_comb begin
      accept    = wr_valid & wr_ready;
      noise_wr  = accept & (wr_data[7] ? (wr_data[6:4] == NOISE_REG) : (ptr == NOISE_REG));
      tone_mode = (rate_sel == 2'd3);
      case (rate_sel)
         2'd0:    term = TC_R0;
         2'd1:    term = TC_R1;
         default: term = TC_R2;
      endcase
   end

   always_ff @(posedge noise_clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         ptr      <= 3'b000;
         fb_mode  <= 1'b0;
         rate_sel <= 2'd0;
         cnt      <= '0;
         shift_en <= 1'b0;
         lfsr_clr <= 1'b0;
         busy     <= 1'b0;
         wr_ready <= 1'b1;
      end else begin
         if (accept && wr_data[7]) begin
            ptr <= wr_data[6:4];
         end
         case (state)
            S_IDLE: begin
               if (noise_wr) begin
                  state    <= S_CLEAR;
                  fb_mode  <= wr_data[2];
                  rate_sel <= wr_data[1:0];
                  lfsr_clr <= 1'b1;
                  busy     <= 1'b1;
                  wr_ready <= 1'b0;
                  cnt      <= '0;
                  shift_en <= 1'b0;
               end else if (tone_mode) begin
                  cnt      <= '0;
                  shift_en <= tone3_pulse;
               end else if (cnt == term) begin
                  cnt      <= '0;
                  shift_en <= 1'b1;
               end else begin
                  cnt      <= cnt + CNT_ONE;
                  shift_en <= 1'b0;
               end
            end
            S_CLEAR: begin
               // The clear cycle counts as phase 0, so the first shift lands P cycles after it;
               // a tone3 pulse sampled here is dropped.
               state    <= S_IDLE;
               lfsr_clr <= 1'b0;
               busy     <= 1'b0;
               wr_ready <= 1'b1;
               shift_en <= 1'b0;
               cnt      <= tone_mode ? '0 : CNT_ONE;
            end
            default: begin
               state    <= S_IDLE;
               lfsr_clr <= 1'b0;
               busy     <= 1'b0;
               wr_ready <= 1'b1;
               shift_en <= 1'b0;
               cnt      <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_noise_ctrl_sched.sv
// Bench for noise_ctrl_sched: stimulus queues expected strobe events, a negedge
// monitor pops and compares them whenever shift_en or lfsr_clr fires.
module tb_noise_ctrl_sched;

   logic       noise_clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       tone3_pulse = 1'b0;
   logic       wr_ready;
   logic       shift_en;
   logic       lfsr_clr;
   logic       fb_mode;
   logic [1:0] rate_sel;
   logic       busy;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      bit         is_clr;
      int         at;
      logic       fb;
      logic [1:0] rate;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   noise_ctrl_sched #(.BASE_DIV(16), .CNT_W(8)) dut (
      .noise_clk  (noise_clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .tone3_pulse(tone3_pulse),
      .shift_en   (shift_en),
      .lfsr_clr   (lfsr_clr),
      .fb_mode    (fb_mode),
      .rate_sel   (rate_sel),
      .busy       (busy)
   );

   always #5 noise_clk = ~noise_clk;

   always @(posedge noise_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_shift(input int at);
      exp_t e;
      e.is_clr = 1'b0;
      e.at     = at;
      e.fb     = 1'b0;
      e.rate   = 2'd0;
      exp_q.push_back(e);
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) @(negedge noise_clk);
   endtask

   // Offer a byte at a negedge, hold until accepted; returns the accepting cycle.
   task automatic write_byte(input logic [7:0] b, input bit noise, input logic fb,
                             input logic [1:0] rate, output int acc);
      exp_t e;
      int   tries;
      wr_valid = 1'b1;
      wr_data  = b;
      tries    = 0;
      while (!wr_ready && tries < 8) begin
         @(negedge noise_clk);
         tries++;
      end
      check("wr_accept_timeout", 32'(wr_ready), 32'd1);
      acc = cyc;
      if (noise) begin
         e.is_clr = 1'b1;
         e.at     = acc + 1;
         e.fb     = fb;
         e.rate   = rate;
         exp_q.push_back(e);
      end
      @(negedge noise_clk);
      wr_valid = 1'b0;
   endtask

   always @(negedge noise_clk) begin
      if (!rst) begin
         while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_event: got none expected %s at cyc %0d (now %0d)",
                     exp_q[0].is_clr ? "lfsr_clr" : "shift_en", exp_q[0].at, cyc);
            void'(exp_q.pop_front());
         end
         if (lfsr_clr || shift_en) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event: got clr=%0b shift=%0b expected none (cyc %0d)",
                        lfsr_clr, shift_en, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               check("event_cycle", 32'(cyc), 32'(mon_e.at));
               check("event_kind", {30'd0, lfsr_clr, shift_en}, mon_e.is_clr ? 32'd2 : 32'd1);
               if (mon_e.is_clr) begin
                  check("clr_fb_mode", 32'(fb_mode), 32'(mon_e.fb));
                  check("clr_rate_sel", 32'(rate_sel), 32'(mon_e.rate));
                  check("clr_busy", 32'(busy), 32'd1);
                  check("clr_wr_ready", 32'(wr_ready), 32'd0);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion (cyc %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, a, b, d, e, g, h, acc;

      repeat (3) @(negedge noise_clk);
      check("rst_shift_en", 32'(shift_en), 32'd0);
      check("rst_lfsr_clr", 32'(lfsr_clr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_fb_mode", 32'(fb_mode), 32'd0);
      check("rst_rate_sel", 32'(rate_sel), 32'd0);

      // free-running divider after reset, rate 0
      rst = 1'b0;
      r = cyc;
      push_shift(r + 16);
      push_shift(r + 32);
      push_shift(r + 48);
      to_cyc(r + 50);

      // latch 0xE5: white noise, rate 1
      write_byte(8'hE5, 1'b1, 1'b1, 2'd1, a);
      push_shift(a + 33);
      push_shift(a + 65);
      push_shift(a + 97);
      to_cyc(a + 99);

      // rate 3: shifts follow tone3 pulses
      write_byte(8'hE7, 1'b1, 1'b1, 2'd3, b);
      for (int k = 0; k < 3; k++) begin
         to_cyc(b + 5 + 10 * k);
         push_shift(b + 6 + 10 * k);
         tone3_pulse = 1'b1;
         @(negedge noise_clk);
         tone3_pulse = 1'b0;
      end
      to_cyc(b + 40);

      // tone3 pulse during the clear cycle is dropped
      write_byte(8'hE7, 1'b1, 1'b1, 2'd3, d);
      tone3_pulse = 1'b1;
      @(negedge noise_clk);
      tone3_pulse = 1'b0;
      to_cyc(d + 5);
      push_shift(d + 6);
      tone3_pulse = 1'b1;
      @(negedge noise_clk);
      tone3_pulse = 1'b0;
      to_cyc(d + 10);

      // latch 0xE0 then data 0x06 to the noise register; second write stalls one cycle
      write_byte(8'hE0, 1'b1, 1'b0, 2'd0, e);
      write_byte(8'h06, 1'b1, 1'b1, 2'd2, acc);
      check("stall_accept_cycle", 32'(acc), 32'(e + 2));
      push_shift(e + 67);
      push_shift(e + 131);
      to_cyc(e + 70);

      // ch0 latch then data byte: no effect on noise settings
      write_byte(8'h80, 1'b0, 1'b0, 2'd0, acc);
      write_byte(8'h06, 1'b0, 1'b0, 2'd0, acc);
      check("ch0_fb_mode_kept", 32'(fb_mode), 32'd1);
      check("ch0_rate_sel_kept", 32'(rate_sel), 32'd2);
      check("ch0_busy", 32'(busy), 32'd0);
      to_cyc(e + 133);

      // reset in the middle of a clear cycle
      write_byte(8'hE5, 1'b1, 1'b1, 2'd1, g);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_lfsr_clr", 32'(lfsr_clr), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_shift_en", 32'(shift_en), 32'd0);
      check("midrst_wr_ready", 32'(wr_ready), 32'd1);
      check("midrst_fb_mode", 32'(fb_mode), 32'd0);
      check("midrst_rate_sel", 32'(rate_sel), 32'd0);
      @(negedge noise_clk);
      rst = 1'b0;
      h = cyc;
      push_shift(h + 16);
      push_shift(h + 32);
      to_cyc(h + 34);

      check("pending_events", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/noise_ctrl_sched.md
Name: noise_ctrl_sched

Overview:
Control and scheduling front-end for the SN76489-style noise channel. It decodes the noise-control writes from the register byte stream and holds the feedback mode and rate select. On every noise-control write it clears the LFSR and re-phases the shift schedule. It also generates the single-cycle shift strobes that advance the LFSR, sourced either from an internal divider or from the channel-3 tone pulse.

Parameters:
BASE_DIV  16  shift period in noise_clk cycles for rate_sel=0; rate 1 uses 2*BASE_DIV, rate 2 uses 4*BASE_DIV
CNT_W     8   divider counter width; must hold 4*BASE_DIV-1

Ports:
noise_clk     input   1  block clock (tone prescaler clock)
rst           input   1  reset, asynchronous, active-high
wr_valid      input   1  register byte offered
wr_data       input   8  register byte, SN76489 format
wr_ready      output  1  byte accepted when wr_valid & wr_ready
tone3_pulse   input   1  one-cycle pulse per channel-3 tone output toggle
shift_en      output  1  one-cycle LFSR advance strobe
lfsr_clr      output  1  one-cycle LFSR reseed strobe (reseed value 1)
fb_mode       output  1  1 = white noise (tapped feedback), 0 = periodic
rate_sel      output  2  current noise rate field
busy          output  1  high while in S_CLEAR

Behaviour:
- Reset state (rst high, async): state=S_IDLE, latch pointer=0 (ch0 tone), fb_mode=0, rate_sel=0, counter=0.
- Outputs during and immediately after reset: shift_en=0, lfsr_clr=0, busy=0, wr_ready=1.
- Byte decode on accept, wr_data[7]=1 (latch byte):
  - pointer <= wr_data[6:4].
  - If wr_data[6:4]==3'b110 (noise control): fb_mode <= wr_data[2]; rate_sel <= wr_data[1:0]; noise write event.
- Byte decode on accept, wr_data[7]=0 (data byte):
  - If pointer==3'b110: fb_mode/rate_sel <= wr_data[2:0] as above; noise write event.
  - Otherwise: ignored here.
- Other latch bytes only move the pointer; they cause no event.
- The pointer persists until the next latch byte.
- FSM states:
  - S_IDLE: wr_ready=1. A noise write event moves to S_CLEAR on the next edge. Any other accepted byte stays in S_IDLE.
  - S_CLEAR: exactly one cycle. lfsr_clr=1, busy=1, wr_ready=0, counter forced to 0, shift_en forced to 0. Returns to S_IDLE.
- New fb_mode/rate_sel are visible in the S_CLEAR cycle, i.e. 1 cycle after the accepting edge.
- lfsr_clr latency: asserted 1 cycle after the accepting edge.
- Back-to-back noise writes are separated by at least one stall cycle.
- Shift scheduling in S_IDLE, rate_sel 0/1/2:
  - P = BASE_DIV << rate_sel.
  - Counter increments each cycle.
  - When counter==P-1: shift_en=1 that cycle and counter wraps to 0.
  - First shift_en after a clear occurs P cycles after the S_CLEAR cycle.
- Shift scheduling in S_IDLE, rate_sel 3:
  - shift_en = registered tone3_pulse, 1 cycle latency.
  - Counter held at 0.
- Simultaneous events:
  - S_CLEAR suppresses shift_en, whether from the divider terminal or from tone3_pulse.
  - tone3_pulse arriving in S_CLEAR is dropped, not deferred.
- Rate change only ever happens via S_CLEAR, so the counter is always re-phased and no truncated or extended period leaks through.
- Reset mid-operation: an S_CLEAR in progress is abandoned and lfsr_clr drops immediately. The downstream LFSR is reset by the same rst.
- Counter arithmetic: unsigned CNT_W bits, compared against P-1. It never exceeds 4*BASE_DIV-1.

Test Plan:
- Reset release, no writes, BASE_DIV=16: shift_en pulses at cycles 16, 32, 48 after reset; fb_mode=0; lfsr_clr never asserts.
- Write latch byte 0xE5 (noise, fb=1, rate=1):
  - wr_ready=0 and lfsr_clr=1 one cycle after accept; fb_mode=1, rate_sel=1.
  - Next shift_en occurs 32 cycles after the clear cycle, then every 32 cycles.
- Write 0xE7 (rate=3) and drive tone3_pulse every 10 cycles: shift_en follows each pulse by 1 cycle.
  - Also drive a pulse coincident with S_CLEAR: that pulse yields no shift_en.
- Write 0xE0, then data byte 0x06: the second write updates fb_mode=1, rate_sel=2 and produces a second lfsr_clr.
  - Then write 0x80 (ch0 latch) followed by 0x06: no lfsr_clr and noise settings unchanged.
- Assert rst during S_CLEAR: lfsr_clr, busy and shift_en drop asynchronously; fb_mode=0, rate_sel=0; wr_ready=1.
  - After release, shift_en appears at cycle 16.
